// File: rtl/cyclic_sequencer.sv
// cyclic_sequencer: N-position cyclic sequencer with up/down stepping,
// parallel load, wrap pulse and rejected-load pulse.
// Optional lap counter enabled by defining the macro CYC_SEQ_LAP_EN;
// without it lap_count is tied to zero and no counter register exists.
module cyclic_sequencer #(
    parameter int NUM_STATES = 3,
    parameter int LAP_W      = 8,
    localparam int SW        = $clog2(NUM_STATES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             restart,
    input  logic             dir,
    input  logic             load,
    input  logic [SW-1:0]    load_val,
    output logic [SW-1:0]    state,
    output logic             odd,
    output logic             even,
    output logic             terminal,
    output logic             wrap,
    output logic             load_err,
    output logic [LAP_W-1:0] lap_count
);

    localparam int            LAST_I = NUM_STATES - 1;
    localparam int            ONE_I  = 1;
    localparam logic [SW-1:0] LAST   = LAST_I[SW-1:0];
    localparam logic [SW-1:0] ONE    = ONE_I[SW-1:0];
    // One bit wider than the index so the bound is representable when
    // NUM_STATES is a power of two.
    localparam logic [SW:0]   COUNT  = NUM_STATES[SW:0];

    typedef enum logic [1:0] {
        OP_ADVANCE,
        OP_HOLD,
        OP_LOAD,
        OP_RESTART
    } op_t;

    op_t           op;
    logic [SW-1:0] start_pos;
    logic [SW-1:0] end_pos;
    logic          state_legal;
    logic          load_legal;
    logic [SW-1:0] state_nxt;
    logic          wrap_nxt;
    logic          load_err_nxt;

    // Position register plus the two single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            wrap     <= wrap_nxt;
            load_err <= load_err_nxt;
        end
    end

    // Select the action by priority and compute the following position.
    always_comb begin
        op           = OP_ADVANCE;
        state_nxt    = state;
        wrap_nxt     = 1'b0;
        load_err_nxt = 1'b0;
        start_pos    = dir ? LAST : '0;
        end_pos      = dir ? '0 : LAST;
        state_legal  = ({1'b0, state} < COUNT);
        load_legal   = ({1'b0, load_val} < COUNT);

        if (restart)    op = OP_RESTART;
        else if (load)  op = OP_LOAD;
        else if (pause) op = OP_HOLD;

        if (!state_legal) begin
            // Recover from an out-of-range index regardless of the request.
            state_nxt = '0;
        end else begin
            case (op)
                OP_RESTART: state_nxt = start_pos;
                OP_LOAD: begin
                    if (load_legal) state_nxt    = load_val;
                    else            load_err_nxt = 1'b1;
                end
                OP_HOLD: state_nxt = state;
                default: begin
                    if (state == end_pos) begin
                        state_nxt = start_pos;
                        wrap_nxt  = 1'b1;
                    end else if (dir) begin
                        state_nxt = state - ONE;
                    end else begin
                        state_nxt = state + ONE;
                    end
                end
            endcase
        end
    end

    // Phase flags follow the 1-based position; terminal flags leaving E.
    always_comb begin
        odd      = ~state[0];
        even     = state[0];
        terminal = ~rst & (state == end_pos) & (restart | (~pause & ~load));
    end

`ifdef CYC_SEQ_LAP_EN
    localparam logic [LAP_W-1:0] LAP_MAX = '1;
    localparam logic [LAP_W-1:0] LAP_ONE = ONE_I[LAP_W-1:0];

    logic [LAP_W-1:0] lap_q;

    // Saturating count of wrap-around advances; restart clears it, load does not.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            lap_q <= '0;
        end else if (wrap_nxt && (lap_q != LAP_MAX)) begin
            lap_q <= lap_q + LAP_ONE;
        end
    end

    assign lap_count = lap_q;
`else
    assign lap_count = '0;
`endif

endmodule
